// File: rtl/fetch_pkg.sv
// Shared fetch definitions: reset PC, word size and the buffered entry layout.
package fetch_pkg;

  localparam logic [31:0] PC_INIT_DEFAULT = 32'h8002_0000;
  localparam logic [31:0] WORD_BYTES      = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction memory, redirect and decoder handshakes.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
    input  imem_gnt, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, halted,
    output imem_gnt, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular FIFO with flush; head output reads zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(fetch_entry_t)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push_s, do_pop_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign do_pop_s  = pop_i && !empty_o && !flush_i;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push_s = push_i && (!full_o || do_pop_s) && !flush_i;
  assign data_o    = empty_o ? {W{1'b0}} : mem_q[rd_q];
  assign count_o   = count_q;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_q <= wr_q + AW'(1);
      if (do_pop_s)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Storage array; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with in-order PC queue, prefetch buffer and redirect flush.
// Optional stop address enabled by defining FETCH_HALT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT   = PC_INIT_DEFAULT,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_ADDR = 32'h8002_0048
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int NW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(DEPTH) + 3;

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          run_q;
  logic          halted_q, halted_d;

  logic [NW-1:0] buf_count_s, pcq_count_s;
  logic          buf_full_s, buf_empty_s, pcq_full_s, pcq_empty_s;
  logic [31:0]   pcq_head_s;
  fetch_entry_t  buf_in_s, buf_head_s;
  logic [CW-1:0] occupancy_s;
  logic          req_s, req_fire_s, rsp_keep_s, rsp_discard_s, rsp_used_s, pop_s;

  // Discarded-but-outstanding responses still reserve slots so nothing is ever dropped.
  assign occupancy_s   = CW'(buf_count_s) + CW'(pcq_count_s) + discard_q;
  assign req_s         = run_q && !halted_q && !bus.redirect && !pcq_full_s && !buf_full_s
                         && (occupancy_s < CW'(DEPTH));
  assign req_fire_s    = req_s && bus.imem_gnt;
  assign rsp_discard_s = bus.imem_rsp_valid && (discard_q != CW'(0));
  assign rsp_keep_s    = bus.imem_rsp_valid && (discard_q == CW'(0)) && !pcq_empty_s && !bus.redirect;
  assign rsp_used_s    = bus.imem_rsp_valid && ((discard_q != CW'(0)) || !pcq_empty_s);
  assign pop_s         = !buf_empty_s && bus.out_ready && !bus.redirect;
  assign buf_in_s      = '{pc: pcq_head_s, instr: bus.imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_pc_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (req_fire_s),
    .pop_i   (rsp_keep_s),
    .flush_i (bus.redirect),
    .data_i  (fetch_pc_q),
    .data_o  (pcq_head_s),
    .full_o  (pcq_full_s),
    .empty_o (pcq_empty_s),
    .count_o (pcq_count_s)
  );

  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rsp_keep_s),
    .pop_i   (pop_s),
    .flush_i (bus.redirect),
    .data_i  (buf_in_s),
    .data_o  (buf_head_s),
    .full_o  (buf_full_s),
    .empty_o (buf_empty_s),
    .count_o (buf_count_s)
  );

  // Next fetch address, discard count and halt flag.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (bus.redirect) begin
      fetch_pc_d = align_word(bus.redirect_pc);
      discard_d  = discard_q + CW'(pcq_count_s) + CW'(req_fire_s) - CW'(rsp_used_s);
    end else begin
      if (req_fire_s) fetch_pc_d = fetch_pc_q + WORD_BYTES;
      if (rsp_discard_s) discard_d = discard_q - CW'(1);
    end
`ifdef FETCH_HALT_EN
    halted_d = (fetch_pc_d == HALT_ADDR);
`else
    halted_d = 1'b0;
`endif
  end

  // Fetch control state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_INIT;
      discard_q  <= {CW{1'b0}};
      run_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_req  = req_s;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = !buf_empty_s;
  assign bus.out_pc    = buf_head_s.pc;
  assign bus.out_instr = buf_head_s.instr;
  assign bus.halted    = halted_q;

endmodule
